// File: rtl/dino_pkg.sv
// Shared types and default constants for the game sequencer.
//   game_state_t : IDLE/RUNNING/DYING/GAME_OVER, encoded exactly as seen on the state port
//   SPEED_INIT_D : default scroll step at game start
//   SPEED_MAX_D  : default scroll step saturation value (3-bit)
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    DYING     = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam int unsigned SPEED_INIT_D = 1;
  localparam int unsigned SPEED_MAX_D  = 7;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// tick_divider: modulo-N event counter with enable, synchronous clear and wrap pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count one event this cycle
//   clr        : return the count to 0 (wins over en)
//   wrap       : combinational, high when an enabled event takes the count from N-1 back to 0
module tick_divider #(
  parameter int unsigned N = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;
  logic         at_top;

  assign at_top = (cnt == W'(N - 1));
  assign wrap   = en & ~clr & at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_top ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: master game-flow controller. Runs the IDLE/RUNNING/DYING/GAME_OVER
// machine, issues start/over pulses, gates the frame tick into obstacle and score ticks
// and (with SPEED_RAMP_EN defined) ramps the scroll speed over time. Without
// SPEED_RAMP_EN the ramp counter is absent and scroll_speed is fixed at SPEED_INIT.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   game_tick_60hz   : one-cycle pulse per video frame
//   button_up        : debounced jump/start level
//   crash            : collision level from graphics
//   state            : 0=IDLE 1=RUNNING 2=DYING 3=GAME_OVER
//   game_start_pulse : one cycle on entry to RUNNING
//   game_over_pulse  : one cycle on entry to DYING
//   obstacle_tick    : frame tick forwarded while RUNNING
//   score_tick       : one pulse every SCORE_DIV running frames
//   scroll_speed     : current scroll step
//   frozen           : high in DYING and GAME_OVER
//
// state     | meaning
// IDLE      | power-up attract screen, waiting for a button press
// RUNNING   | game in play, ticks forwarded, speed ramping
// DYING     | crash freeze, waits DEAD_FRAMES frames
// GAME_OVER | frozen until a fresh button press restarts
module game_sequencer
  import dino_pkg::*;
#(
  parameter int unsigned SPEED_INIT  = SPEED_INIT_D,
  parameter int unsigned SPEED_MAX   = SPEED_MAX_D,
  parameter int unsigned RAMP_FRAMES = 600,
  parameter int unsigned SCORE_DIV   = 6,
  parameter int unsigned DEAD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_tick_60hz,
  input  logic       button_up,
  input  logic       crash,
  output logic [1:0] state,
  output logic       game_start_pulse,
  output logic       game_over_pulse,
  output logic       obstacle_tick,
  output logic       score_tick,
  output logic [2:0] scroll_speed,
  output logic       frozen
);

  if (SPEED_MAX > 7 || SPEED_INIT > SPEED_MAX) begin : g_bad_speed
    $error("game_sequencer: speed parameters must fit 3 bits with SPEED_INIT <= SPEED_MAX");
  end
  if (RAMP_FRAMES < 1 || SCORE_DIV < 1 || DEAD_FRAMES < 1) begin : g_bad_div
    $error("game_sequencer: divider parameters must be at least 1");
  end

  game_state_t st;
  logic        btn_q;
  logic        start_evt;
  logic        can_start;
  logic        run_tick;
  logic        dead_tick;
  logic        enter_dying;
  logic        score_wrap;
  logic        dead_wrap;

  assign start_evt   = button_up & ~btn_q;
  assign can_start   = ((st == IDLE) || (st == GAME_OVER)) & start_evt;
  // crash beats a same-cycle tick, so the tick is neither forwarded nor counted
  assign run_tick    = (st == RUNNING) & ~crash & game_tick_60hz;
  assign enter_dying = (st == RUNNING) & crash;
  assign dead_tick   = (st == DYING) & game_tick_60hz;
  assign state       = st;

  tick_divider #(.N(SCORE_DIV)) u_score (
    .clk(clk), .rst_n(rst_n), .en(run_tick), .clr(can_start), .wrap(score_wrap)
  );

  tick_divider #(.N(DEAD_FRAMES)) u_dead (
    .clk(clk), .rst_n(rst_n), .en(dead_tick), .clr(enter_dying), .wrap(dead_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st               <= IDLE;
      btn_q            <= 1'b0;
      game_start_pulse <= 1'b0;
      game_over_pulse  <= 1'b0;
      obstacle_tick    <= 1'b0;
      score_tick       <= 1'b0;
      frozen           <= 1'b0;
    end else begin
      // btn_q tracks the button in every state, so a press held through DYING
      // produces no edge once GAME_OVER is reached
      btn_q            <= button_up;
      game_start_pulse <= 1'b0;
      game_over_pulse  <= 1'b0;
      obstacle_tick    <= 1'b0;
      score_tick       <= 1'b0;
      unique case (st)
        IDLE, GAME_OVER: begin
          if (can_start) begin
            st               <= RUNNING;
            game_start_pulse <= 1'b1;
            frozen           <= 1'b0;
          end
        end
        RUNNING: begin
          if (enter_dying) begin
            st              <= DYING;
            game_over_pulse <= 1'b1;
            frozen          <= 1'b1;
          end else if (run_tick) begin
            obstacle_tick <= 1'b1;
            score_tick    <= score_wrap;
          end
        end
        DYING: begin
          if (dead_wrap) st <= GAME_OVER;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef SPEED_RAMP_EN
  logic       ramp_wrap;
  logic [2:0] speed_q;

  tick_divider #(.N(RAMP_FRAMES)) u_ramp (
    .clk(clk), .rst_n(rst_n), .en(run_tick), .clr(can_start), .wrap(ramp_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= 3'(SPEED_INIT);
    end else if (can_start) begin
      speed_q <= 3'(SPEED_INIT);
    end else if (ramp_wrap && (speed_q < 3'(SPEED_MAX))) begin
      speed_q <= speed_q + 3'd1;
    end
  end

  assign scroll_speed = speed_q;
`else
  assign scroll_speed = 3'(SPEED_INIT);
`endif

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  import dino_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_tick_60hz;
  logic       button_up;
  logic       crash;
  logic [1:0] state;
  logic       game_start_pulse;
  logic       game_over_pulse;
  logic       obstacle_tick;
  logic       score_tick;
  logic [2:0] scroll_speed;
  logic       frozen;

  int vectors = 0;
  int errors  = 0;
  int obs_cnt, score_cnt, start_cnt, over_cnt;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .game_tick_60hz(game_tick_60hz),
    .button_up(button_up), .crash(crash), .state(state),
    .game_start_pulse(game_start_pulse), .game_over_pulse(game_over_pulse),
    .obstacle_tick(obstacle_tick), .score_tick(score_tick),
    .scroll_speed(scroll_speed), .frozen(frozen)
  );

  always #5 clk = ~clk;

`ifdef SPEED_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // apply inputs for one cycle; on return outputs show the response to them
  task automatic drive(input logic t, input logic b, input logic c);
    game_tick_60hz = t;
    button_up      = b;
    crash          = c;
    @(negedge clk);
    obs_cnt   += int'(obstacle_tick);
    score_cnt += int'(score_tick);
    start_cnt += int'(game_start_pulse);
    over_cnt  += int'(game_over_pulse);
  endtask

  task automatic clear_counts();
    obs_cnt = 0; score_cnt = 0; start_cnt = 0; over_cnt = 0;
  endtask

  // n frames: tick cycle followed by a quiet cycle
  task automatic frames(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, b, 1'b0);
      drive(1'b0, b, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; game_tick_60hz = 1'b0; button_up = 1'b0; crash = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_start_pulse", int'(game_start_pulse), 0);
    check("rst_over_pulse", int'(game_over_pulse), 0);
    check("rst_speed", int'(scroll_speed), 1);
    check("rst_frozen", int'(frozen), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // idle: ticks not forwarded, crash ignored
    clear_counts();
    frames(5, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("idle_state", int'(state), 0);
    check("idle_obs", obs_cnt, 0);
    check("idle_score", score_cnt, 0);
    check("idle_crash_ignored", over_cnt, 0);
    check("idle_speed", int'(scroll_speed), 1);

    // start from idle
    clear_counts();
    drive(1'b0, 1'b1, 1'b0);
    check("start_pulse", int'(game_start_pulse), 1);
    check("start_state", int'(state), 1);
    check("start_frozen", int'(frozen), 0);
    drive(1'b0, 1'b1, 1'b0);
    check("start_pulse_once", int'(game_start_pulse), 0);

    // 12 frames with button held: no retrigger
    clear_counts();
    frames(12, 1'b1);
    check("run12_obs", obs_cnt, 12);
    check("run12_score", score_cnt, 2);
    check("run12_no_restart", start_cnt, 0);
    check("run12_speed", int'(scroll_speed), 1);

    // speed ramp: 12 frames so far
    frames(587, 1'b0);
    check("ramp_599", int'(scroll_speed), 1);
    frames(1, 1'b0);
    check("ramp_600", int'(scroll_speed), RAMP ? 2 : 1);
    frames(599, 1'b0);
    check("ramp_1199", int'(scroll_speed), RAMP ? 2 : 1);
    frames(1, 1'b0);
    check("ramp_1200", int'(scroll_speed), RAMP ? 3 : 1);
    frames(600, 1'b0);
    check("ramp_1800", int'(scroll_speed), RAMP ? 4 : 1);
    frames(1800, 1'b0);
    check("ramp_3600_sat", int'(scroll_speed), RAMP ? 7 : 1);
    frames(600, 1'b0);
    check("ramp_4200_hold", int'(scroll_speed), RAMP ? 7 : 1);
    check("ramp_state", int'(state), 1);

    // 4200 frames is a multiple of 6; five more leave score counter at 5
    clear_counts();
    frames(5, 1'b0);
    check("pre_crash_score", score_cnt, 0);
    check("pre_crash_obs", obs_cnt, 5);

    // crash with simultaneous tick: would otherwise yield score_tick too
    clear_counts();
    drive(1'b1, 1'b0, 1'b1);
    check("crash_over_pulse", int'(game_over_pulse), 1);
    check("crash_no_obs", int'(obstacle_tick), 0);
    check("crash_no_score", int'(score_tick), 0);
    check("crash_state", int'(state), 2);
    check("crash_frozen", int'(frozen), 1);
    drive(1'b0, 1'b1, 1'b1);
    check("crash_pulse_once", int'(game_over_pulse), 0);

    // dying: button pressed and held, ignored; GAME_OVER after 60 ticks
    clear_counts();
    frames(59, 1'b1);
    check("dying_59_state", int'(state), 2);
    frames(1, 1'b1);
    check("dying_60_state", int'(state), 3);
    check("over_frozen", int'(frozen), 1);
    check("over_speed_hold", int'(scroll_speed), RAMP ? 7 : 1);
    frames(3, 1'b1);
    check("held_no_restart_state", int'(state), 3);
    check("held_no_start_pulse", start_cnt, 0);
    check("dying_no_obs", obs_cnt, 0);

    // release, re-press together with a tick: start wins, tick not forwarded
    drive(1'b0, 1'b0, 1'b0);
    clear_counts();
    drive(1'b1, 1'b1, 1'b0);
    check("restart_pulse", int'(game_start_pulse), 1);
    check("restart_no_obs", int'(obstacle_tick), 0);
    check("restart_state", int'(state), 1);
    check("restart_speed", int'(scroll_speed), 1);
    check("restart_frozen", int'(frozen), 0);
    drive(1'b0, 1'b1, 1'b0);
    clear_counts();
    frames(5, 1'b1);
    check("restart_score5", score_cnt, 0);
    frames(1, 1'b1);
    check("restart_score6", score_cnt, 1);
    check("restart_obs6", obs_cnt, 6);

    // reset while DYING
    drive(1'b0, 1'b0, 1'b1);
    check("dying2_state", int'(state), 2);
    drive(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_frozen", int'(frozen), 0);
    check("async_rst_over", int'(game_over_pulse), 0);
    check("async_rst_start", int'(game_start_pulse), 0);
    @(negedge clk);
    clear_counts();
    drive(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("post_rst_state", int'(state), 0);
    check("post_rst_pulses", start_cnt + over_cnt + obs_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
